// File: rtl/memory_access_unit.sv
// memory_access_unit: single-outstanding load/store initiator for a
// sync-read data memory with a registered output. Loads wait a fixed
// READ_LATENCY before capturing mem_data_out; stores complete in one cycle.
module memory_access_unit #(
  parameter int ADDR_WIDTH   = 12,
  parameter int DATA_WIDTH   = 16,
  parameter int READ_LATENCY = 2
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_address,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  busy,
  output logic                  mem_write,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_data_in,
  input  logic [DATA_WIDTH-1:0] mem_data_out
);

  // Counter is wide enough to hold READ_LATENCY; it counts down to zero and stops.
  localparam int CNT_W = $clog2(READ_LATENCY + 2);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITE     = 2'd1,
    READ_WAIT = 2'd2,
    RESP      = 2'd3
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] wait_cnt;
  logic             accept;
  logic             last_wait;

  // RESP accepts too, so a new request can follow a load response with no bubble.
  assign req_ready = (state == IDLE) || (state == RESP);
  assign busy      = (state != IDLE);
  assign accept    = req_valid && req_ready;
  assign last_wait = (state == READ_WAIT) && (wait_cnt == '0);

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, RESP: begin
        if (accept) state_nxt = req_write ? WRITE : READ_WAIT;
        else        state_nxt = IDLE;
      end
      WRITE:     state_nxt = IDLE;
      READ_WAIT: if (wait_cnt == '0) state_nxt = RESP;
      default:   state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Read-latency counter: loaded on load accept, decremented through READ_WAIT.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wait_cnt <= '0;
    end else if (accept && !req_write) begin
      wait_cnt <= CNT_W'(READ_LATENCY);
    end else if ((state == READ_WAIT) && (wait_cnt != '0)) begin
      wait_cnt <= wait_cnt - 1'b1;
    end
  end

  // Memory-side drive: address/data only move on accept, write strobe is one cycle.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mem_write   <= 1'b0;
      mem_address <= '0;
      mem_data_in <= '0;
    end else begin
      mem_write <= accept && req_write;
      if (accept)              mem_address <= req_address;
      if (accept && req_write) mem_data_in <= req_wdata;
    end
  end

  // Response: pulse on entry to WRITE or RESP; load data captured on the last wait cycle.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      resp_valid <= 1'b0;
      resp_rdata <= '0;
    end else begin
      resp_valid <= (state_nxt == WRITE) || (state_nxt == RESP);
      if (last_wait) resp_rdata <= mem_data_out;
    end
  end

endmodule

// File: tb/tb_memory_access_unit.sv
// Bench for memory_access_unit: behavioural RAM on the memory side, a plain
// array reference memory, and fixed-latency expectations per request type.
module tb_memory_access_unit;

  localparam int AW = 12;
  localparam int DW = 16;
  localparam int RL = 2;
  localparam int LOAD_LAT = RL + 2;

  logic          clock = 1'b0;
  logic          reset_n;
  logic          req_valid, req_ready, req_write;
  logic [AW-1:0] req_address;
  logic [DW-1:0] req_wdata;
  logic          resp_valid;
  logic [DW-1:0] resp_rdata;
  logic          busy;
  logic          mem_write;
  logic [AW-1:0] mem_address;
  logic [DW-1:0] mem_data_in;
  logic [DW-1:0] mem_data_out;

  int n_checks = 0;
  int n_fail   = 0;
  int mw_cnt   = 0;
  int resp_cnt = 0;

  logic [DW-1:0] ram     [4096];
  logic [DW-1:0] ref_mem [4096];
  logic [DW-1:0] ram_q;

  memory_access_unit #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(RL)) dut (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_address(req_address), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .busy(busy),
    .mem_write(mem_write), .mem_address(mem_address),
    .mem_data_in(mem_data_in), .mem_data_out(mem_data_out)
  );

  always #5 clock = ~clock;

  // Data memory: synchronous read plus output register, read-before-write.
  always @(posedge clock) begin
    if (mem_write) ram[mem_address] <= mem_data_in;
    ram_q        <= ram[mem_address];
    mem_data_out <= ram_q;
  end

  // Event counters for write strobes and response pulses.
  always @(posedge clock) begin
    if (reset_n && mem_write)  mw_cnt   <= mw_cnt + 1;
    if (reset_n && resp_valid) resp_cnt <= resp_cnt + 1;
  end

  // Issue one request (caller sits just after a negedge) and report what was seen.
  task automatic access(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        output int lat, output logic [DW-1:0] rd, output logic mw1,
                        output logic [AW-1:0] ma1, output logic [DW-1:0] md1);
    int guard = 0;
    lat = -1; rd = 'x; mw1 = 'x; ma1 = 'x; md1 = 'x;
    while (req_ready !== 1'b1 && guard < 10) begin
      @(negedge clock);
      guard++;
    end
    if (req_ready !== 1'b1) return;
    req_valid = 1'b1; req_write = wr; req_address = a; req_wdata = d;
    @(posedge clock);
    for (int k = 1; k <= 20; k++) begin
      @(negedge clock);
      if (k == 1) begin
        mw1 = mem_write; ma1 = mem_address; md1 = mem_data_in;
        req_valid = 1'b0;
        req_write = 1'($urandom); req_address = AW'($urandom); req_wdata = DW'($urandom);
      end
      if (resp_valid === 1'b1) begin
        lat = k; rd = resp_rdata;
        break;
      end
    end
  endtask

  task automatic test_reset();
    int lat; logic [DW-1:0] rd; logic mw1; logic [AW-1:0] ma1; logic [DW-1:0] md1;
    int rc;
    reset_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_address = '0; req_wdata = '0;
    repeat (3) @(negedge clock);
    n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready got %b want 1", req_ready); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    n_checks++; if (resp_valid !== 1'b0 || resp_rdata !== '0) begin n_fail++; $display("FAIL reset_resp got %b/%h want 0/0000", resp_valid, resp_rdata); end
    n_checks++; if (mem_write !== 1'b0 || mem_address !== '0 || mem_data_in !== '0) begin n_fail++; $display("FAIL reset_mem got %b/%h/%h want 0/000/0000", mem_write, mem_address, mem_data_in); end
    reset_n = 1'b1;
    @(negedge clock);
    // Make resp_rdata non-zero so the mid-load reset has something to clear.
    access(1'b1, 12'h055, 16'hA5A5, lat, rd, mw1, ma1, md1); ref_mem[12'h055] = 16'hA5A5;
    access(1'b0, 12'h055, 16'h0, lat, rd, mw1, ma1, md1);
    n_checks++; if (rd !== 16'hA5A5) begin n_fail++; $display("FAIL reset_preload got %h want a5a5", rd); end
    @(negedge clock);
    rc = resp_cnt;
    req_valid = 1'b1; req_write = 1'b0; req_address = 12'h055;
    @(posedge clock);           // accept in cycle A
    @(negedge clock);           // A+1
    req_valid = 1'b0;
    @(negedge clock);           // A+2
    #1 reset_n = 1'b0;
    #1;
    n_checks++; if (resp_rdata !== '0) begin n_fail++; $display("FAIL reset_mid_rdata got %h want 0000", resp_rdata); end
    n_checks++; if (mem_write !== 1'b0) begin n_fail++; $display("FAIL reset_mid_mem_write got %b want 0", mem_write); end
    n_checks++; if (req_ready !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL reset_mid_ready got %b/%b want 1/0", req_ready, busy); end
    @(negedge clock);
    reset_n = 1'b1;
    repeat (6) @(negedge clock);
    n_checks++; if (resp_cnt !== rc) begin n_fail++; $display("FAIL reset_no_resp got %0d want %0d", resp_cnt, rc); end
  endtask

  task automatic test_store_load();
    int lat; logic [DW-1:0] rd; logic mw1; logic [AW-1:0] ma1; logic [DW-1:0] md1;
    int mw0 = mw_cnt;
    access(1'b1, 12'h123, 16'hBEEF, lat, rd, mw1, ma1, md1); ref_mem[12'h123] = 16'hBEEF;
    n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL store_latency got %0d want 1", lat); end
    n_checks++; if (mw1 !== 1'b1 || ma1 !== 12'h123 || md1 !== 16'hBEEF) begin n_fail++; $display("FAIL store_mem got %b/%h/%h want 1/123/beef", mw1, ma1, md1); end
    n_checks++; if (rd !== 16'hA5A5 && rd !== 16'h0000) begin n_fail++; $display("FAIL store_rdata_hold got %h want unchanged", rd); end
    access(1'b0, 12'h123, 16'h0, lat, rd, mw1, ma1, md1);
    n_checks++; if (lat !== LOAD_LAT) begin n_fail++; $display("FAIL load_latency got %0d want %0d", lat, LOAD_LAT); end
    n_checks++; if (mw1 !== 1'b0 || ma1 !== 12'h123) begin n_fail++; $display("FAIL load_mem got %b/%h want 0/123", mw1, ma1); end
    n_checks++; if (rd !== 16'hBEEF) begin n_fail++; $display("FAIL load_rdata got %h want beef", rd); end
    @(negedge clock); @(negedge clock);
    n_checks++; if (mw_cnt - mw0 !== 1) begin n_fail++; $display("FAIL store_one_pulse got %0d want 1", mw_cnt - mw0); end
  endtask

  task automatic test_back_to_back();
    int lat; logic [DW-1:0] rd; logic mw1; logic [AW-1:0] ma1; logic [DW-1:0] md1;
    access(1'b1, 12'h001, 16'h1111, lat, rd, mw1, ma1, md1); ref_mem[12'h001] = 16'h1111;
    access(1'b0, 12'h001, 16'h0, lat, rd, mw1, ma1, md1);
    n_checks++; if (rd !== 16'h1111) begin n_fail++; $display("FAIL b2b_load got %h want 1111", rd); end
    // Still in the response cycle: unit must be busy and ready together.
    n_checks++; if (busy !== 1'b1 || req_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_resp_ready got %b/%b want 1/1", busy, req_ready); end
    access(1'b1, 12'h002, 16'h2222, lat, rd, mw1, ma1, md1); ref_mem[12'h002] = 16'h2222;
    n_checks++; if (lat !== 1 || mw1 !== 1'b1 || ma1 !== 12'h002 || md1 !== 16'h2222) begin n_fail++; $display("FAIL b2b_store got lat %0d %b/%h/%h want 1 1/002/2222", lat, mw1, ma1, md1); end
    access(1'b0, 12'h002, 16'h0, lat, rd, mw1, ma1, md1);
    n_checks++; if (rd !== 16'h2222 || lat !== LOAD_LAT) begin n_fail++; $display("FAIL b2b_readback got %h lat %0d want 2222 lat %0d", rd, lat, LOAD_LAT); end
    @(negedge clock);
  endtask

  task automatic test_busy_reject();
    int rc, mw0, moved = 0;
    logic [DW-1:0] got;
    @(negedge clock);
    rc = resp_cnt; mw0 = mw_cnt;
    req_valid = 1'b1; req_write = 1'b0; req_address = 12'h123;
    @(posedge clock);
    for (int k = 1; k <= RL + 1; k++) begin
      @(negedge clock);
      if (mem_address !== 12'h123) moved++;
      req_write = 1'($urandom); req_address = AW'($urandom); req_wdata = DW'($urandom);
    end
    @(negedge clock);
    req_valid = 1'b0;
    got = resp_rdata;
    n_checks++; if (moved !== 0) begin n_fail++; $display("FAIL busy_addr_hold got %0d changes want 0", moved); end
    n_checks++; if (resp_valid !== 1'b1 || got !== 16'hBEEF) begin n_fail++; $display("FAIL busy_resp got %b/%h want 1/beef", resp_valid, got); end
    repeat (4) @(negedge clock);
    n_checks++; if (resp_cnt - rc !== 1 || mw_cnt !== mw0) begin n_fail++; $display("FAIL busy_one_resp got resp %0d writes %0d want 1 0", resp_cnt - rc, mw_cnt - mw0); end
  endtask

  task automatic test_boundaries();
    int lat; logic [DW-1:0] rd; logic mw1; logic [AW-1:0] ma1; logic [DW-1:0] md1;
    logic [AW-1:0] addrs [4] = '{12'h000, 12'hFFF, 12'h000, 12'hFFF};
    logic [DW-1:0] datas [4] = '{16'hFFFF, 16'h0000, 16'h0000, 16'hFFFF};
    for (int i = 0; i < 4; i += 2) begin
      access(1'b1, addrs[i],   datas[i],   lat, rd, mw1, ma1, md1); ref_mem[addrs[i]]   = datas[i];
      access(1'b1, addrs[i+1], datas[i+1], lat, rd, mw1, ma1, md1); ref_mem[addrs[i+1]] = datas[i+1];
      for (int j = i; j < i + 2; j++) begin
        access(1'b0, addrs[j], 16'h0, lat, rd, mw1, ma1, md1);
        n_checks++; if (rd !== datas[j] || ma1 !== addrs[j]) begin n_fail++; $display("FAIL boundary_%0d got %h@%h want %h@%h", j, rd, ma1, datas[j], addrs[j]); end
      end
    end
    @(negedge clock);
  endtask

  task automatic test_random();
    int lat; logic [DW-1:0] rd; logic mw1; logic [AW-1:0] ma1; logic [DW-1:0] md1;
    int mw0 = mw_cnt, rc0 = resp_cnt, stores = 0, bad = 0;
    bit wr; logic [AW-1:0] a; logic [DW-1:0] d;
    for (int i = 0; i < 200; i++) begin
      wr = 1'($urandom_range(0, 1));
      a  = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 15));
      d  = DW'($urandom);
      access(wr, a, d, lat, rd, mw1, ma1, md1);
      if (wr) begin
        stores++;
        ref_mem[a] = d;
        n_checks++; if (lat !== 1 || mw1 !== 1'b1 || ma1 !== a || md1 !== d) begin n_fail++; bad++; if (bad < 6) $display("FAIL rand_store_%0d got lat %0d %b/%h/%h want 1 1/%h/%h", i, lat, mw1, ma1, md1, a, d); end
      end else begin
        n_checks++; if (lat !== LOAD_LAT || rd !== ref_mem[a]) begin n_fail++; bad++; if (bad < 6) $display("FAIL rand_load_%0d got lat %0d %h want lat %0d %h", i, lat, rd, LOAD_LAT, ref_mem[a]); end
      end
    end
    repeat (3) @(negedge clock);
    n_checks++; if (mw_cnt - mw0 !== stores) begin n_fail++; $display("FAIL rand_write_pulses got %0d want %0d", mw_cnt - mw0, stores); end
    n_checks++; if (resp_cnt - rc0 !== 200) begin n_fail++; $display("FAIL rand_resp_count got %0d want 200", resp_cnt - rc0); end
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) begin
      ram[i] = '0;
      ref_mem[i] = '0;
    end
    test_reset();
    test_store_load();
    test_back_to_back();
    test_busy_reject();
    test_boundaries();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/memory_access_unit.md
Name: memory_access_unit

Overview:
- Initiator-side controller driving the 4K x 16 data memory block (sync-read RAM plus registered output) on behalf of the processor load/store path.
- Accepts one load or store at a time over a valid/ready request port and drives mem_write/address/data_in.
- Counts the fixed memory read latency, captures read data, and returns a one-cycle response pulse.
- Sits between the datapath load/store logic and the data memory instance.

Parameters:
ADDR_WIDTH, 12, memory word address width
DATA_WIDTH, 16, memory word width
READ_LATENCY, 2, edges from mem_address issue to valid mem_data_out (1 RAM sync read + 1 output register)

Ports:
clock  input  1  system clock, rising edge
reset_n  input  1  asynchronous, active-low reset
req_valid  input  1  request present
req_ready  output  1  unit can accept a request this cycle
req_write  input  1  1 = store, 0 = load; sampled on accept
req_address  input  ADDR_WIDTH  word address; sampled on accept
req_wdata  input  DATA_WIDTH  store data; sampled on accept
resp_valid  output  1  one-cycle completion pulse (load or store)
resp_rdata  output  DATA_WIDTH  last captured load data
busy  output  1  high whenever state != IDLE
mem_write  output  1  to data memory mem_write
mem_address  output  ADDR_WIDTH  to data memory address
mem_data_in  output  DATA_WIDTH  to data memory data_in
mem_data_out  input  DATA_WIDTH  from data memory data_out

Behaviour:
- Clocking and reset: all outputs registered except req_ready and busy, which decode state. Clocked on clock; reset_n asynchronous, active-low.
- Reset values: state IDLE, mem_write 0, mem_address 0, mem_data_in 0, resp_valid 0, resp_rdata 0, wait counter 0. Hence req_ready 1 and busy 0 during and after reset.
- Reset mid-operation: abandons the access immediately; mem_write drops asynchronously; no response is issued.
- States: IDLE, WRITE, READ_WAIT, RESP.
- Accept: occurs in cycle A when req_valid && req_ready. req_ready = 1 only in IDLE and RESP. Requests while req_ready = 0 are ignored, not queued.
- Store accepted in A:
  - Cycle A+1 is state WRITE: mem_write = 1, mem_address = req_address, mem_data_in = req_wdata, resp_valid = 1.
  - Cycle A+2 is IDLE.
  - Exactly one mem_write cycle per store; resp_rdata unchanged.
- Load accepted in A:
  - mem_write stays 0; mem_address = req_address from A+1.
  - READ_WAIT lasts READ_LATENCY+1 cycles (A+1..A+3 at default); counter loads READ_LATENCY and decrements.
  - mem_data_out is captured into resp_rdata at the end of the last READ_WAIT cycle.
  - RESP in cycle A+READ_LATENCY+2 (A+4): resp_valid = 1.
  - Accept-to-response latency is READ_LATENCY+2 cycles.
- Address hold: mem_address and mem_data_in hold their last values in all states. Only an accept updates them.
- RESP transitions:
  - If a new request is accepted in RESP, go to WRITE or READ_WAIT directly, back-to-back with no IDLE bubble.
  - Otherwise go to IDLE.
- resp_valid: never high for two consecutive cycles except back-to-back store-after-load (RESP then WRITE). resp_rdata holds until the next load capture.
- Read-after-write: the store commits at the end of A+1. A load accepted in A+2 or later returns the new data.
- No arithmetic beyond the wait counter, which is width ceil(log2(READ_LATENCY+2)) and never wraps.

Test Plan:
- Reset: assert reset_n = 0 mid-load (cycle A+2) -> resp_rdata = 0, mem_write = 0, req_ready = 1 immediately; no resp_valid after release.
- Store then load: store 0xBEEF to 0x123 -> mem_write = 1 for exactly one cycle with address 0x123 and data 0xBEEF, resp_valid same cycle. Load 0x123 accepted 1 cycle later -> resp_valid 4 cycles after accept, resp_rdata = 0xBEEF.
- Back-to-back: load 0x001 (holding 0x1111) with a store of 0x2222 to 0x002 presented during RESP -> accepted in RESP; mem_write next cycle. Load 0x002 then returns 0x2222.
- Busy rejection: hold req_valid = 1 with varying address during READ_WAIT -> no mem_address change and no extra accept; exactly one resp_valid per accepted request.
- Boundaries: store/load at 0x000 and 0xFFF with data 0x0000 and 0xFFFF -> correct round trip, no address aliasing.
- Scoreboard: 200 random requests against a reference memory model -> every load matches; mem_write pulses equal the number of stores.
